// File: rtl/reset_tick_gen_if.sv
// Signal bundle between reset_tick_gen and the top level: the raw button combo in,
// the tick/reset sequencing outputs and the FSM debug state out.
interface reset_tick_gen_if #(
  parameter int NBTN = 3
);
  logic [NBTN-1:0] manual;
  logic            tick;
  logic            tick_sq;
  logic            rst_out;
  logic            rst_done;
  logic [1:0]      state_dbg;

  // Plain level signals with no handshake: the generator drives every output on
  // each clock, and the consumer samples them whenever it needs to.
  modport master (
    output manual,
    input  tick,
    input  tick_sq,
    input  rst_out,
    input  rst_done,
    input  state_dbg
  );

  modport slave (
    input  manual,
    output tick,
    output tick_sq,
    output rst_out,
    output rst_done,
    output state_dbg
  );
endinterface

// File: rtl/reset_tick_gen.sv
// Tick divider plus reset sequencer. It produces a power-on reset pulse
// HOLD_TICKS ticks long and re-runs that pulse after a debounced all-buttons combo.
module reset_tick_gen #(
  parameter int CLK_HZ         = 12000000,
  parameter int TICK_HZ        = 100,
  parameter int HOLD_TICKS     = 4,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int NBTN           = 3
) (
  input  logic             clk,
  input  logic             reset,
  reset_tick_gen_if.slave  bus
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int CTR_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PRESS = 2'd3
  } state_e;

  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic              tick_q, tick_d;
  logic              tick_sq_q, tick_sq_d;
  logic [NBTN-1:0]   sync1_q, sync2_q;
  logic              combo;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              pressed_q, pressed_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rst_out_q, rst_out_d;
  logic              rst_done_q, rst_done_d;

  // ---------------------------------------------------------------------------
  // Divider: tick_q is high exactly in the cycle where ctr_q == DIV-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctr_d     = ctr_q;
    tick_d    = 1'b0;
    tick_sq_d = tick_sq_q;
    if (ctr_q == CTR_LAST) begin
      ctr_d     = '0;
      tick_sq_d = ~tick_sq_q;
    end else begin
      ctr_d = ctr_q + 1'b1;
    end
    tick_d = (ctr_d == CTR_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q     <= '0;
      tick_q    <= 1'b0;
      tick_sq_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      tick_q    <= tick_d;
      tick_sq_q <= tick_sq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchroniser and tick-rate debouncer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.manual;
      sync2_q <= sync1_q;
    end
  end

  assign combo = &sync2_q;

  // Counts consecutive samples that disagree with the current debounced level.
  // A sample that agrees clears the count.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (tick_q) begin
      if (combo != pressed_q) begin
        if (db_cnt_q == DB_LAST) begin
          pressed_d = combo;
          db_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM. It acts only on tick cycles and sees the debounced level as
  // it stood before this tick's debouncer update.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rst_out_d  = 1'b0;
    rst_done_d = 1'b0;
    if (tick_q) begin
      if (pressed_q && (state_q != ST_PRESS)) begin
        state_d = ST_PRESS;
      end else begin
        case (state_q)
          ST_LOW: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d = ST_RUN;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            state_d = ST_RUN;
          end
          ST_PRESS: begin
            if (!pressed_q) begin
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
          default: begin
            state_d = ST_LOW;
          end
        endcase
      end
    end
    // Outputs are decoded from the next state so that the flops hold them
    // glitch-free and aligned with state_q.
    rst_out_d  = (state_d == ST_HOLD) || (state_d == ST_PRESS);
    rst_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOW;
      hold_cnt_q <= '0;
      rst_out_q  <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_out_q  <= rst_out_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.tick_sq   = tick_sq_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.rst_done  = rst_done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_reset_tick_gen.sv
// Bench for reset_tick_gen with DIV=10, HOLD_TICKS=4, DEBOUNCE_TICKS=3, NBTN=3.
// A tick-level behavioural model is compared every cycle, and directed literal checks are added.
module tb_reset_tick_gen;

  localparam int DIV  = 10;
  localparam int HOLD = 4;
  localparam int DEB  = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   cyc;

  reset_tick_gen_if #(.NBTN(3)) bus ();

  reset_tick_gen #(
    .CLK_HZ(100), .TICK_HZ(10), .HOLD_TICKS(HOLD), .DEBOUNCE_TICKS(DEB), .NBTN(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: m_n counts clocks since reset release. The tick and the
  // square wave follow arithmetically from it. The debouncer and the sequencer
  // advance once per tick.
  int m_n, m_state, m_hold, m_run;
  bit m_pressed, m_h0, m_h1;

  always @(posedge clk or posedge reset) begin : model
    int st, hd, rn;
    bit pr, old_pr;
    if (reset) begin
      m_n <= 0; m_state <= 0; m_hold <= 0; m_run <= 0;
      m_pressed <= 1'b0; m_h0 <= 1'b0; m_h1 <= 1'b0;
    end else begin
      st = m_state; hd = m_hold; rn = m_run; pr = m_pressed;
      if (m_n % DIV == DIV - 1) begin
        old_pr = pr;
        if (m_h1 != pr) begin
          rn = rn + 1;
          if (rn == DEB) begin pr = m_h1; rn = 0; end
        end else begin
          rn = 0;
        end
        if (old_pr && st != 3) st = 3;
        else if (st == 0) begin st = 1; hd = 0; end
        else if (st == 1) begin
          if (hd == HOLD - 1) st = 2;
          else hd = hd + 1;
        end
        else if (st == 3 && !old_pr) begin st = 1; hd = 0; end
      end
      m_state <= st; m_hold <= hd; m_run <= rn; m_pressed <= pr;
      m_h1 <= m_h0;
      m_h0 <= &bus.manual;
      m_n <= m_n + 1;
    end
  end

  // Compare process: runs on every falling edge
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tick", bus.tick, 0);
      chk("rst_tick_sq", bus.tick_sq, 0);
      chk("rst_rst_out", bus.rst_out, 0);
      chk("rst_rst_done", bus.rst_done, 0);
      chk("rst_state", bus.state_dbg, 0);
    end else begin
      chk("tick", bus.tick, (m_n % DIV == DIV - 1) ? 1 : 0);
      chk("tick_sq", bus.tick_sq, (m_n / DIV) % 2);
      chk("rst_out", bus.rst_out, (m_state == 1 || m_state == 3) ? 1 : 0);
      chk("rst_done", bus.rst_done, (m_state == 2) ? 1 : 0);
      chk("state_dbg", bus.state_dbg, m_state);
    end
  end

  // Driver tasks
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_manual(input logic [2:0] v);
    #1 bus.manual = v;
  endtask

  task automatic power_on_checks();
    goto(8);  chk("po_tick_c8", bus.tick, 0);
    goto(9);  chk("po_tick_c9", bus.tick, 1);
              chk("po_rst_out_c9", bus.rst_out, 0);
              chk("po_sq_c9", bus.tick_sq, 0);
    goto(10); chk("po_rst_out_c10", bus.rst_out, 1);
              chk("po_sq_c10", bus.tick_sq, 1);
    goto(19); chk("po_tick_c19", bus.tick, 1);
    goto(49); chk("po_rst_out_c49", bus.rst_out, 1);
              chk("po_done_c49", bus.rst_done, 0);
    goto(50); chk("po_rst_out_c50", bus.rst_out, 0);
              chk("po_done_c50", bus.rst_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus.manual = 3'b000;

    // Power-on sequence
    do_reset();
    power_on_checks();

    // Combo held 5 ticks enters PRESS, and release re-runs HOLD
    goto(60);  set_manual(3'b111);
    goto(99);  chk("pr_state_c99", bus.state_dbg, 2);
    goto(100); chk("pr_state_c100", bus.state_dbg, 3);
               chk("pr_rst_out_c100", bus.rst_out, 1);
    goto(110); chk("pr_state_c110", bus.state_dbg, 3);
               set_manual(3'b000);
    goto(149); chk("pr_state_c149", bus.state_dbg, 3);
    goto(150); chk("pr_state_c150", bus.state_dbg, 1);
    goto(189); chk("pr_state_c189", bus.state_dbg, 1);
    goto(190); chk("pr_state_c190", bus.state_dbg, 2);

    // A two-tick glitch never leaves RUN
    goto(200); set_manual(3'b111);
    goto(220); set_manual(3'b110);
    goto(260); chk("gl_state_c260", bus.state_dbg, 2);
               chk("gl_rst_out_c260", bus.rst_out, 0);

    // A partial combo is ignored
    set_manual(3'b101);
    goto(370); chk("pc_state_c370", bus.state_dbg, 2);
               set_manual(3'b000);

    // Reset asserted during HOLD with hold_cnt=2, then the full sequence repeats
    do_reset();
    goto(34);  chk("mr_rst_out_c34", bus.rst_out, 1);
    #1 reset = 1'b1;
    #1;
    chk("mr_rst_out_now", bus.rst_out, 0);
    chk("mr_done_now", bus.rst_done, 0);
    chk("mr_tick_now", bus.tick, 0);
    chk("mr_ctr_now", int'(dut.ctr_q), 0);
    chk("mr_state_now", bus.state_dbg, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    power_on_checks();

    // Combo held from release: PRESS is taken from HOLD while the tick keeps running
    bus.manual = 3'b111;
    do_reset();
    goto(39);  chk("lp_state_c39", bus.state_dbg, 1);
    goto(40);  chk("lp_state_c40", bus.state_dbg, 3);
    goto(45);  chk("lp_sq_c45", bus.tick_sq, 0);
    goto(55);  chk("lp_sq_c55", bus.tick_sq, 1);
    goto(60);  set_manual(3'b000);
    goto(100); chk("lp_state_c100", bus.state_dbg, 1);
    goto(139); chk("lp_state_c139", bus.state_dbg, 1);
    goto(140); chk("lp_state_c140", bus.state_dbg, 2);
               chk("lp_done_c140", bus.rst_done, 1);
    goto(150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
